// File: rtl/mem_client_arbiter.sv
// Two-client round-robin arbiter onto one memory server port.
// Requests are registered once; responses route back by an opaque source bit.
module mem_client_arbiter #(
  parameter int unsigned p_opaq_bits       = 8,
  parameter int unsigned p_max_outstanding = 4
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   c0_req_val,
  output logic                   c0_req_rdy,
  input  logic [p_opaq_bits+64:0] c0_req_msg,
  output logic                   c0_resp_val,
  input  logic                   c0_resp_rdy,
  output logic [p_opaq_bits+32:0] c0_resp_msg,

  input  logic                   c1_req_val,
  output logic                   c1_req_rdy,
  input  logic [p_opaq_bits+64:0] c1_req_msg,
  output logic                   c1_resp_val,
  input  logic                   c1_resp_rdy,
  output logic [p_opaq_bits+32:0] c1_resp_msg,

  output logic                   s_req_val,
  input  logic                   s_req_rdy,
  output logic [p_opaq_bits+65:0] s_req_msg,
  input  logic                   s_resp_val,
  output logic                   s_resp_rdy,
  input  logic [p_opaq_bits+33:0] s_resp_msg
);

  localparam int unsigned CQ = p_opaq_bits + 65;
  localparam int unsigned SQ = p_opaq_bits + 66;
  localparam int unsigned CP = p_opaq_bits + 33;
  localparam int unsigned SP = p_opaq_bits + 34;
  localparam int unsigned CW = $clog2(p_max_outstanding) + 1;
  localparam logic [CW-1:0] MAX = CW'(p_max_outstanding);

  logic          val_q, val_d;
  logic [SQ-1:0] msg_q, msg_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;

  logic can_acc;
  logic el0, el1;
  logic g0, g1;
  logic acc0, acc1;
  logic dec0, dec1;
  logic k;
  logic [CP-1:0] rmsg;

  // Source bit sits just below op, i.e. as the MSB of the server opaque.
  function automatic logic [SQ-1:0] tag(
    input logic          src,
    input logic [CQ-1:0] m
  );
    return {m[CQ-1], src, m[CQ-2:0]};
  endfunction

  always_comb begin
    can_acc = !val_q || s_req_rdy;
    el0 = c0_req_val && (cnt0_q < MAX);
    el1 = c1_req_val && (cnt1_q < MAX);
    g0 = el0 && (!prio_q || !el1);
    g1 = el1 && (prio_q || !el0);
    c0_req_rdy = can_acc && g0 && !rst;
    c1_req_rdy = can_acc && g1 && !rst;
    acc0 = c0_req_val && c0_req_rdy;
    acc1 = c1_req_val && c1_req_rdy;
  end

  always_comb begin
    k = s_resp_msg[SP-2];
    rmsg = {s_resp_msg[SP-1], s_resp_msg[SP-3:0]};
    c0_resp_val = s_resp_val && !k;
    c1_resp_val = s_resp_val && k;
    c0_resp_msg = rmsg;
    c1_resp_msg = rmsg;
    s_resp_rdy = k ? c1_resp_rdy : c0_resp_rdy;
    dec0 = c0_resp_val && c0_resp_rdy;
    dec1 = c1_resp_val && c1_resp_rdy;
  end

  always_comb begin
    val_d  = val_q;
    msg_d  = msg_q;
    prio_d = prio_q;
    if (can_acc) begin
      val_d = acc0 || acc1;
      if (acc0) begin
        msg_d  = tag(1'b0, c0_req_msg);
        prio_d = 1'b1;
      end else if (acc1) begin
        msg_d  = tag(1'b1, c1_req_msg);
        prio_d = 1'b0;
      end
    end
  end

  // A response against an empty counter never underflows it.
  always_comb begin
    cnt0_d = cnt0_q;
    if (acc0 && !dec0)
      cnt0_d = cnt0_q + 1'b1;
    else if (!acc0 && dec0 && cnt0_q != '0)
      cnt0_d = cnt0_q - 1'b1;
    cnt1_d = cnt1_q;
    if (acc1 && !dec1)
      cnt1_d = cnt1_q + 1'b1;
    else if (!acc1 && dec1 && cnt1_q != '0)
      cnt1_d = cnt1_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= 1'b0;
      msg_q  <= '0;
      prio_q <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      val_q  <= val_d;
      msg_q  <= msg_d;
      prio_q <= prio_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign s_req_val = val_q;
  assign s_req_msg = msg_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dec0 && cnt0_q == '0))
        else $error("client 0 response with no request outstanding");
      assert (!(dec1 && cnt1_q == '0))
        else $error("client 1 response with no request outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_mem_client_arbiter.sv
// Directed bench for mem_client_arbiter.
// Default parameters: 8-bit client opaque, 4 outstanding per client.
module tb_mem_client_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req_val, c0_req_rdy;
  logic [72:0] c0_req_msg;
  logic        c0_resp_val, c0_resp_rdy;
  logic [40:0] c0_resp_msg;
  logic        c1_req_val, c1_req_rdy;
  logic [72:0] c1_req_msg;
  logic        c1_resp_val, c1_resp_rdy;
  logic [40:0] c1_resp_msg;
  logic        s_req_val, s_req_rdy;
  logic [73:0] s_req_msg;
  logic        s_resp_val, s_resp_rdy;
  logic [41:0] s_resp_msg;

  int ncmp = 0;
  int nerr = 0;

  mem_client_arbiter dut (
    .clk(clk), .rst(rst),
    .c0_req_val(c0_req_val), .c0_req_rdy(c0_req_rdy),
    .c0_req_msg(c0_req_msg),
    .c0_resp_val(c0_resp_val), .c0_resp_rdy(c0_resp_rdy),
    .c0_resp_msg(c0_resp_msg),
    .c1_req_val(c1_req_val), .c1_req_rdy(c1_req_rdy),
    .c1_req_msg(c1_req_msg),
    .c1_resp_val(c1_resp_val), .c1_resp_rdy(c1_resp_rdy),
    .c1_resp_msg(c1_resp_msg),
    .s_req_val(s_req_val), .s_req_rdy(s_req_rdy),
    .s_req_msg(s_req_msg),
    .s_resp_val(s_resp_val), .s_resp_rdy(s_resp_rdy),
    .s_resp_msg(s_resp_msg)
  );

  always #5 clk = ~clk;

  function automatic logic [72:0] cq(logic op, logic [7:0] o,
                                     logic [31:0] a, logic [31:0] d);
    return {op, o, a, d};
  endfunction

  function automatic logic [73:0] sq(logic op, logic [8:0] o,
                                     logic [31:0] a, logic [31:0] d);
    return {op, o, a, d};
  endfunction

  function automatic logic [41:0] sp(logic op, logic [8:0] o,
                                     logic [31:0] d);
    return {op, o, d};
  endfunction

  function automatic logic [40:0] cp(logic op, logic [7:0] o,
                                     logic [31:0] d);
    return {op, o, d};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [72:0] ma, mb;

  initial begin
    rst = 1'b1;
    c0_req_val = 1'b0; c0_req_msg = '0; c0_resp_rdy = 1'b1;
    c1_req_val = 1'b0; c1_req_msg = '0; c1_resp_rdy = 1'b1;
    s_req_rdy = 1'b0; s_resp_val = 1'b0; s_resp_msg = '0;

    // reset behaviour
    tick();
    c0_req_val = 1'b1;
    #1 chk("rst_c0_rdy", c0_req_rdy, 0);
    chk("rst_c1_rdy", c1_req_rdy, 0);
    tick();
    chk("rst_sval", s_req_val, 0);
    c0_req_val = 1'b0;
    rst = 1'b0;

    // single c0 read and its response
    s_req_rdy = 1'b1;
    c0_req_val = 1'b1;
    c0_req_msg = cq(1'b0, 8'h05, 32'h200, 32'h0);
    #1 chk("t1_c0_rdy", c0_req_rdy, 1);
    chk("t1_c1_rdy", c1_req_rdy, 0);
    tick();
    c0_req_val = 1'b0;
    chk("t1_sval", s_req_val, 1);
    chk("t1_smsg", s_req_msg, sq(1'b0, 9'h005, 32'h200, 32'h0));
    s_resp_val = 1'b1;
    s_resp_msg = sp(1'b0, 9'h005, 32'hDEADBEEF);
    #1 chk("t1_r0_val", c0_resp_val, 1);
    chk("t1_r0_msg", c0_resp_msg, cp(1'b0, 8'h05, 32'hDEADBEEF));
    chk("t1_r1_val", c1_resp_val, 0);
    chk("t1_srdy", s_resp_rdy, 1);
    tick();
    s_resp_val = 1'b0;
    chk("t1_drain", s_req_val, 0);

    // round-robin alternation from reset
    do_reset();
    c0_req_val = 1'b1;
    c0_req_msg = cq(1'b0, 8'h11, 32'h1000, 32'h0);
    c1_req_val = 1'b1;
    c1_req_msg = cq(1'b1, 8'h22, 32'h2000, 32'hCAFE);
    for (int j = 0; j < 4; j++) begin
      #1 chk("t2_g0", c0_req_rdy, (j % 2) == 0);
      chk("t2_g1", c1_req_rdy, (j % 2) == 1);
      tick();
      chk("t2_src", s_req_msg[72], (j % 2) == 1);
    end
    chk("t2_c1msg", s_req_msg, sq(1'b1, 9'h122, 32'h2000, 32'hCAFE));
    c0_req_val = 1'b0;
    c1_req_val = 1'b0;

    // c1 outstanding cap
    do_reset();
    c1_req_val = 1'b1;
    c1_req_msg = cq(1'b1, 8'h33, 32'h3000, 32'h1);
    for (int j = 0; j < 4; j++) begin
      #1 chk("t3_c1_rdy", c1_req_rdy, 1);
      tick();
    end
    c0_req_val = 1'b1;
    c0_req_msg = cq(1'b0, 8'h44, 32'h4000, 32'h0);
    #1 chk("t3_c1_cap", c1_req_rdy, 0);
    chk("t3_c0_ok", c0_req_rdy, 1);
    tick();
    c0_req_val = 1'b0;
    chk("t3_c0_src", s_req_msg[72], 0);
    s_resp_val = 1'b1;
    s_resp_msg = sp(1'b1, 9'h133, 32'h0);
    #1 chk("t3_r1_val", c1_resp_val, 1);
    chk("t3_r0_val", c0_resp_val, 0);
    chk("t3_still", c1_req_rdy, 0);
    tick();
    s_resp_val = 1'b0;
    #1 chk("t3_freed", c1_req_rdy, 1);
    c1_req_val = 1'b0;

    // stall with full register, then 1/cycle refill
    do_reset();
    s_req_rdy = 1'b0;
    ma = cq(1'b0, 8'hA0, 32'hA000, 32'hA);
    mb = cq(1'b1, 8'hB0, 32'hB000, 32'hB);
    c0_req_val = 1'b1;
    c0_req_msg = ma;
    #1 chk("t4_first", c0_req_rdy, 1);
    tick();
    c1_req_val = 1'b1;
    c1_req_msg = mb;
    for (int j = 0; j < 3; j++) begin
      #1 chk("t4_c0_stall", c0_req_rdy, 0);
      chk("t4_c1_stall", c1_req_rdy, 0);
      chk("t4_hold_val", s_req_val, 1);
      chk("t4_hold_msg", s_req_msg, sq(1'b0, 9'h0A0, 32'hA000, 32'hA));
      tick();
    end
    s_req_rdy = 1'b1;
    #1 chk("t4_refill", c1_req_rdy, 1);
    tick();
    chk("t4_msg_b", s_req_msg, sq(1'b1, 9'h1B0, 32'hB000, 32'hB));
    chk("t4_c0_next", c0_req_rdy, 1);
    tick();
    chk("t4_msg_a", s_req_msg, sq(1'b0, 9'h0A0, 32'hA000, 32'hA));

    // held c1 response does not block c0 requests
    c1_req_val = 1'b0;
    c1_resp_rdy = 1'b0;
    s_resp_val = 1'b1;
    s_resp_msg = sp(1'b1, 9'h1B0, 32'h12345678);
    #1 chk("t5_srdy", s_resp_rdy, 0);
    chk("t5_r1_val", c1_resp_val, 1);
    chk("t5_c0_rdy", c0_req_rdy, 1);
    tick();
    chk("t5_c0_acc", s_req_val, 1);
    chk("t5_c0_src", s_req_msg[72], 0);
    chk("t5_held", c1_resp_msg, cp(1'b1, 8'hB0, 32'h12345678));
    c1_resp_rdy = 1'b1;
    #1 chk("t5_srdy1", s_resp_rdy, 1);
    tick();
    s_resp_val = 1'b0;
    c0_req_val = 1'b0;

    // reset mid-operation
    do_reset();
    c0_req_val = 1'b1;
    c0_req_msg = ma;
    c1_req_val = 1'b1;
    c1_req_msg = mb;
    for (int j = 0; j < 4; j++) tick();
    c0_req_val = 1'b0;
    c1_req_val = 1'b0;
    s_req_rdy = 1'b0;
    chk("t6_full", s_req_val, 1);
    do_reset();
    chk("t6_sval", s_req_val, 0);
    c0_req_val = 1'b1;
    c1_req_val = 1'b1;
    #1 chk("t6_prio0", c0_req_rdy, 1);
    chk("t6_prio1", c1_req_rdy, 0);
    c0_req_val = 1'b0;
    s_req_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1 chk("t6_cnt_clr", c1_req_rdy, 1);
      tick();
    end
    #1 chk("t6_cnt_cap", c1_req_rdy, 0);
    c1_req_val = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
